// File: rtl/ledwalk_sequencer.sv
// ledwalk_sequencer: on request, walks a single lit LED up and down the strip
// for a latched number of sweeps. A prescaler sets the step rate. The block
// reports busy and done, and it can be aborted.
module ledwalk_sequencer #(
    parameter int NLEDS = 8,
    parameter int CW    = 24,
    parameter int IW    = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CW-1:0]    i_div,
    input  logic [3:0]       i_passes,
    output logic             o_busy,
    output logic             o_done,
    output logic [NLEDS-1:0] o_led,
    output logic [IW-1:0]    o_index
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    localparam logic [IW-1:0]    LAST_IDX = IW'(NLEDS - 1);
    localparam logic [IW-1:0]    IDX_ONE  = IW'(1);
    localparam logic [CW-1:0]    DIV_ONE  = CW'(1);
    localparam logic [3:0]       PASS_ONE = 4'd1;
    localparam logic [NLEDS-1:0] LED0     = NLEDS'(1);

    state_t             state, state_next;
    logic [CW-1:0]      prescale, prescale_next;
    logic [CW-1:0]      div_eff, div_eff_next;
    logic [3:0]         passes_left, passes_left_next;
    logic [IW-1:0]      index, index_next;
    logic [NLEDS-1:0]   led, led_next;
    logic               busy, busy_next;
    logic               done, done_next;

    logic               step;
    logic [IW-1:0]      index_up;
    logic [IW-1:0]      index_down;
    logic [3:0]         passes_dec;
    logic [CW-1:0]      start_div;
    logic [3:0]         start_passes;

    // Step strobe fires on prescaler underflow. The walk helpers and the
    // zero-clamped start configuration are also computed here.
    always_comb begin
        step         = (prescale == '0);
        index_up     = index + IDX_ONE;
        index_down   = index - IDX_ONE;
        passes_dec   = passes_left - PASS_ONE;
        start_div    = (i_div == '0) ? DIV_ONE : i_div;
        start_passes = (i_passes == '0) ? PASS_ONE : i_passes;
    end

    // Next-state, prescaler and output logic. Abort outranks a step.
    always_comb begin
        state_next       = state;
        prescale_next    = prescale;
        div_eff_next     = div_eff;
        passes_left_next = passes_left;
        index_next       = index;
        busy_next        = busy;
        done_next        = 1'b0;

        case (state)
            IDLE: begin
                if (i_start && !i_abort) begin
                    div_eff_next     = start_div;
                    passes_left_next = start_passes;
                    prescale_next    = start_div - DIV_ONE;
                    index_next       = '0;
                    busy_next        = 1'b1;
                    state_next       = UP;
                end
            end

            UP, DOWN: begin
                if (i_abort) begin
                    state_next    = IDLE;
                    busy_next     = 1'b0;
                    index_next    = '0;
                    prescale_next = '0;
                end else if (step) begin
                    prescale_next = div_eff - DIV_ONE;
                    if (state == UP) begin
                        index_next = index_up;
                        if (index_up == LAST_IDX) begin
                            state_next = DOWN;
                        end
                    end else begin
                        index_next = index_down;
                        if (index_down == '0) begin
                            passes_left_next = passes_dec;
                            if (passes_dec == '0) begin
                                state_next = IDLE;
                                busy_next  = 1'b0;
                                done_next  = 1'b1;
                            end else begin
                                state_next = UP;
                            end
                        end
                    end
                end else begin
                    prescale_next = prescale - DIV_ONE;
                end
            end

            default: begin
                state_next    = IDLE;
                busy_next     = 1'b0;
                index_next    = '0;
                prescale_next = '0;
            end
        endcase

        led_next = LED0 << index_next;
    end

    // State register. Reset is asynchronous and returns every register to its idle value.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            prescale    <= '0;
            div_eff     <= DIV_ONE;
            passes_left <= '0;
            index       <= '0;
            led         <= LED0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            prescale    <= prescale_next;
            div_eff     <= div_eff_next;
            passes_left <= passes_left_next;
            index       <= index_next;
            led         <= led_next;
            busy        <= busy_next;
            done        <= done_next;
        end
    end

    assign o_busy  = busy;
    assign o_done  = done;
    assign o_led   = led;
    assign o_index = index;

endmodule

// File: tb/tb_ledwalk_sequencer.sv
// Testbench for ledwalk_sequencer. A reference model predicts every change of
// the (index, busy, done) outputs, including the clock cycle of the change.
// A monitor compares each observed change against the predicted one.
module tb_ledwalk_sequencer;

    localparam int NLEDS = 8;
    localparam int CW    = 24;
    localparam int IW    = 4;
    localparam int PASS_STEPS = 2 * (NLEDS - 1);

    logic             i_clk;
    logic             i_reset;
    logic             i_start;
    logic             i_abort;
    logic [CW-1:0]    i_div;
    logic [3:0]       i_passes;
    logic             o_busy;
    logic             o_done;
    logic [NLEDS-1:0] o_led;
    logic [IW-1:0]    o_index;

    ledwalk_sequencer #(.NLEDS(NLEDS), .CW(CW), .IW(IW)) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_start  (i_start),
        .i_abort  (i_abort),
        .i_div    (i_div),
        .i_passes (i_passes),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_led    (o_led),
        .o_index  (o_index)
    );

    typedef struct {
        int   cyc;
        int   idx;
        logic busy;
        logic done;
    } ev_t;

    ev_t exp_q[$];
    int  asserts  = 0;
    int  failures = 0;
    int  cyc      = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Position of the lit LED after s steps of a triangular up/down walk.
    function automatic int walk_idx(input int s);
        int p;
        p = s % PASS_STEPS;
        return (p <= NLEDS - 1) ? p : PASS_STEPS - p;
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        asserts++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Reference model: a walk is defined by its start cycle, divider and total step count.
    initial begin : model
        bit   m_active;
        int   m_t0, m_div, m_total, s;
        int   e_idx, p_idx;
        logic e_busy, e_done, p_busy, p_done;
        m_active = 0; m_t0 = 0; m_div = 1; m_total = 0;
        e_idx = 0; e_busy = 0; e_done = 0;
        p_idx = 0; p_busy = 0; p_done = 0;
        forever begin
            @(posedge i_clk or posedge i_reset);
            if (i_reset) begin
                m_active = 0;
                e_idx = 0; e_busy = 0; e_done = 0;
            end else begin
                cyc++;
                e_done = 0;
                if (m_active) begin
                    if (i_abort) begin
                        m_active = 0;
                        e_idx = 0; e_busy = 0;
                    end else begin
                        s = (cyc - m_t0) / m_div;
                        if (s >= m_total) begin
                            m_active = 0;
                            e_idx = 0; e_busy = 0; e_done = 1;
                        end else begin
                            e_idx = walk_idx(s); e_busy = 1;
                        end
                    end
                end else if (i_start && !i_abort) begin
                    m_active = 1;
                    m_t0     = cyc;
                    m_div    = (i_div == 0) ? 1 : int'(i_div);
                    m_total  = ((i_passes == 0) ? 1 : int'(i_passes)) * PASS_STEPS;
                    e_idx = 0; e_busy = 1;
                end else begin
                    e_idx = 0; e_busy = 0;
                end
            end
            if (e_idx != p_idx || e_busy != p_busy || e_done != p_done) begin
                exp_q.push_back('{cyc: cyc, idx: e_idx, busy: e_busy, done: e_done});
                p_idx = e_idx; p_busy = e_busy; p_done = e_done;
            end
        end
    end

    // Monitor: checks invariants every cycle and scores each output change.
    initial begin : monitor
        int   m_idx;
        logic m_busy, m_done;
        logic [NLEDS-1:0] oh;
        ev_t  ev;
        m_idx = 0; m_busy = 0; m_done = 0;
        forever begin
            @(negedge i_clk);
            oh = NLEDS'(1) << o_index;
            asserts++;
            if (o_led !== oh || int'(o_index) > NLEDS - 1 || (o_done && o_busy)) begin
                failures++;
                $display("FAIL invariant: led=%h index=%0d busy=%b done=%b at cycle %0d",
                         o_led, o_index, o_busy, o_done, cyc);
            end
            if (int'(o_index) != m_idx || o_busy !== m_busy || o_done !== m_done) begin
                asserts++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change: got idx=%0d busy=%b done=%b, none expected, cycle %0d",
                             o_index, o_busy, o_done, cyc);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.cyc != cyc || ev.idx != int'(o_index) || ev.busy !== o_busy || ev.done !== o_done) begin
                        failures++;
                        $display("FAIL scoreboard: got idx=%0d busy=%b done=%b at cycle %0d, expected idx=%0d busy=%b done=%b at cycle %0d",
                                 o_index, o_busy, o_done, cyc, ev.idx, ev.busy, ev.done, ev.cyc);
                    end
                end
                m_idx = int'(o_index); m_busy = o_busy; m_done = o_done;
            end
        end
    end

    // While waiting, scramble the config inputs to show they are latched only at start.
    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (o_busy && n < budget) begin
            i_div    = CW'($urandom);
            i_passes = 4'($urandom);
            tick();
            n++;
        end
        if (o_busy) begin
            asserts++;
            failures++;
            $display("FAIL timeout_idle: busy still %b after %0d cycles, required 0", o_busy, budget);
        end
        tick();
        tick();
    endtask

    task automatic run_walk(input int div, input int passes);
        i_div    = CW'(div);
        i_passes = 4'(passes);
        i_start  = 1'b1;
        tick();
        i_start  = 1'b0;
        check_int("busy_after_start", int'(o_busy), 1);
        wait_idle(5000);
    endtask

    initial begin : stim
        int n;
        i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        i_div = '0; i_passes = '0;
        repeat (3) tick();
        i_reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_int("idle_led", int'(o_led), 1);
            check_int("idle_state", int'({o_index, o_busy, o_done}), 0);
        end

        run_walk(1, 1);
        run_walk(3, 2);
        run_walk(0, 0);
        run_walk(2, 3);

        // Abort, with a second start ignored while busy, then a fresh start.
        i_div = CW'(1); i_passes = 4'd1;
        i_start = 1'b1; tick();
        i_start = 1'b0; tick();
        tick();
        i_start = 1'b1; tick();
        i_start = 1'b0;
        check_int("ignored_start_idx", int'(o_index), 3);
        tick();
        i_abort = 1'b1; tick();
        i_abort = 1'b0;
        check_int("abort_busy", int'(o_busy), 0);
        check_int("abort_led", int'(o_led), 1);
        tick();
        i_start = 1'b1; tick();
        i_start = 1'b0;
        check_int("restart_busy", int'(o_busy), 1);
        check_int("restart_idx", int'(o_index), 0);
        wait_idle(5000);

        // Back-to-back: start held high restarts in the cycle done is high.
        i_div = CW'(2); i_passes = 4'd1;
        i_start = 1'b1;
        n = 0;
        while (!o_done && n < 500) begin tick(); n++; end
        check_int("b2b_done_seen", int'(o_done), 1);
        tick();
        i_start = 1'b0;
        check_int("b2b_restart_busy", int'(o_busy), 1);
        wait_idle(5000);

        // Asynchronous reset between edges while index is 5.
        i_div = CW'(1); i_passes = 4'd2;
        i_start = 1'b1; tick();
        i_start = 1'b0;
        n = 0;
        while (o_index != 4'd5 && n < 100) begin tick(); n++; end
        check_int("reach_idx5", int'(o_index), 5);
        #6;
        i_reset = 1'b1;
        #1;
        check_int("async_rst_led", int'(o_led), 1);
        check_int("async_rst_busy", int'(o_busy), 0);
        tick(); tick();
        i_reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_int("post_rst_idle", int'(o_busy), 0);
        end

        // Randomized traffic: starts, aborts and config changes at any time.
        for (int i = 0; i < 3000; i++) begin
            i_start  = ($urandom_range(0, 7) == 0);
            i_abort  = ($urandom_range(0, 63) == 0);
            i_div    = CW'($urandom_range(0, 4));
            i_passes = 4'($urandom_range(0, 2));
            tick();
        end
        i_start = 1'b0; i_abort = 1'b0;
        wait_idle(5000);
        repeat (3) tick();
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
